// File: rtl/dec3to8_strobe.sv
// Registered 3-to-8 one-hot strobe decoder with valid/ready intake, a one-entry
// pending buffer, programmable hold/gap timing. Optional parity check: DEC_PARITY_EN.
module dec3to8_strobe #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] A,
`ifdef DEC_PARITY_EN
   input  logic       A_par,
   output logic       err,
`endif
   output logic [7:0] Y,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int               MAX_CYC   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);

   if (CNT_W < $clog2(MAX_CYC)) begin : g_bad_cnt_w
      $error("dec3to8_strobe: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
   end
   if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255) || (GAP_CYCLES < 0) || (GAP_CYCLES > 255)) begin : g_bad_timing
      $error("dec3to8_strobe: HOLD_CYCLES must be 1..255 and GAP_CYCLES 0..255");
   end

   function automatic logic [7:0] onehot(input logic [2:0] code);
      logic [7:0] y;
      case (code)
         3'd0:    y = 8'b0000_0001;
         3'd1:    y = 8'b0000_0010;
         3'd2:    y = 8'b0000_0100;
         3'd3:    y = 8'b0000_1000;
         3'd4:    y = 8'b0001_0000;
         3'd5:    y = 8'b0010_0000;
         3'd6:    y = 8'b0100_0000;
         3'd7:    y = 8'b1000_0000;
         default: y = 8'b0000_0000;
      endcase
      return y;
   endfunction

`ifdef DEC_PARITY_EN
   function automatic logic parity_bad(input logic [2:0] code, input logic par);
      return ^{code, par};
   endfunction
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       code_q, code_d;
   logic             pend_valid_q, pend_valid_d;
   logic [2:0]       pend_code_q, pend_code_d;
   logic [7:0]       y_q, y_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept, take_new, have_next;
   logic [2:0]       next_code;

   // Readiness depends only on registered state, never on in_valid.
   assign in_ready = !rst && ((state_q == ST_IDLE) || !pend_valid_q);
   assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
   logic err_q, err_d;
   assign take_new = accept && !parity_bad(A, A_par);
   assign err_d    = accept &&  parity_bad(A, A_par);
   assign err      = err_q;
`else
   assign take_new = accept;
`endif

   // A code arriving in the very cycle a strobe/gap ends is started directly.
   assign have_next = pend_valid_q || take_new;
   assign next_code = pend_valid_q ? pend_code_q : A;

   // Next-state, counter, pending buffer and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      code_d       = code_q;
      pend_valid_d = pend_valid_q;
      pend_code_d  = pend_code_q;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (take_new) begin
               code_d  = A;
               cnt_d   = HOLD_LOAD;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
               if (take_new) begin
                  pend_valid_d = 1'b1;
                  pend_code_d  = A;
               end else begin
                  pend_valid_d = pend_valid_q;
               end
            end else begin
               done_d = 1'b1;
               if (HAS_GAP) begin
                  cnt_d   = GAP_LOAD;
                  state_d = ST_GAP;
                  if (take_new) begin
                     pend_valid_d = 1'b1;
                     pend_code_d  = A;
                  end else begin
                     pend_valid_d = pend_valid_q;
                  end
               end else if (have_next) begin
                  code_d       = next_code;
                  pend_valid_d = 1'b0;
                  cnt_d        = HOLD_LOAD;
                  state_d      = ST_DRIVE;
               end else begin
                  cnt_d   = CNT_ZERO;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
               if (take_new) begin
                  pend_valid_d = 1'b1;
                  pend_code_d  = A;
               end else begin
                  pend_valid_d = pend_valid_q;
               end
            end else if (have_next) begin
               code_d       = next_code;
               pend_valid_d = 1'b0;
               cnt_d        = HOLD_LOAD;
               state_d      = ST_DRIVE;
            end else begin
               cnt_d   = CNT_ZERO;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            cnt_d        = CNT_ZERO;
            pend_valid_d = 1'b0;
         end
      endcase
      y_d    = (state_d == ST_DRIVE) ? onehot(code_d) : 8'h00;
      busy_d = (state_d != ST_IDLE) || pend_valid_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= CNT_ZERO;
         code_q       <= 3'd0;
         pend_valid_q <= 1'b0;
         pend_code_q  <= 3'd0;
         y_q          <= 8'h00;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         code_q       <= code_d;
         pend_valid_q <= pend_valid_d;
         pend_code_q  <= pend_code_d;
         y_q          <= y_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef DEC_PARITY_EN
   // Parity error pulse register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

   assign Y    = y_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_dec3to8_strobe.sv
// Self-checking bench for dec3to8_strobe: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0)
// checked every cycle against a strobe-schedule model, plus directed scenarios.
module tb_dec3to8_strobe;
   localparam int H_A = 4, G_A = 1, H_B = 1, G_B = 0;
   localparam int MAXS = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, v_a, v_b, rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;
   logic [2:0] a_a, a_b;
   logic [7:0] y_a, y_b;
`ifdef DEC_PARITY_EN
   logic p_a, p_b, err_a, err_b;
`endif

   dec3to8_strobe #(.HOLD_CYCLES(H_A), .GAP_CYCLES(G_A), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(rdy_a), .A(a_a),
`ifdef DEC_PARITY_EN
      .A_par(p_a), .err(err_a),
`endif
      .Y(y_a), .busy(busy_a), .done(done_a));

   dec3to8_strobe #(.HOLD_CYCLES(H_B), .GAP_CYCLES(G_B), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(v_b), .in_ready(rdy_b), .A(a_b),
`ifdef DEC_PARITY_EN
      .A_par(p_b), .err(err_b),
`endif
      .Y(y_b), .busy(busy_b), .done(done_b));

   // Model: list of scheduled strobes (code, first drive cycle) per instance.
   int   st_start [2][MAXS];
   int   st_code  [2][MAXS];
   int   st_n     [2];
   int   hold     [2];
   int   gap      [2];
   logic err_exp  [2];

   int   cyc, checks, errors, done_b_cnt;
   logic acc_a, acc_b, rec_on;
   logic [7:0] rec_q[$];
   logic [7:0] q_exp [15] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00,
                              8'h40, 8'h40, 8'h40, 8'h40, 8'h00,
                              8'h02, 8'h02, 8'h02, 8'h02, 8'h00};

   function automatic logic [7:0] m_y(int d, int c);
      logic [7:0] y = 8'h00;
      for (int i = 0; i < st_n[d]; i++)
         if (st_start[d][i] <= c && c < st_start[d][i] + hold[d]) y = 8'(1 << st_code[d][i]);
      return y;
   endfunction

   function automatic logic m_done(int d, int c);
      logic r = 1'b0;
      for (int i = 0; i < st_n[d]; i++)
         if (st_start[d][i] + hold[d] == c) r = 1'b1;
      return r;
   endfunction

   function automatic logic m_busy(int d, int c);
      logic r = 1'b0;
      for (int i = 0; i < st_n[d]; i++)
         if (c < st_start[d][i] + hold[d] + gap[d]) r = 1'b1;
      return r;
   endfunction

   function automatic logic m_ready(int d, int c);
      logic r = !rst;
      for (int i = 0; i < st_n[d]; i++)
         if (st_start[d][i] > c) r = 1'b0;
      return r;
   endfunction

   // Edge update: c is the cycle that ends at this edge. Returns 1 on a transfer.
   function automatic logic m_edge(int d, int c, logic v, logic [2:0] a, logic bad, logic rdy);
      int s;
      err_exp[d] = 1'b0;
      if (rst) begin
         st_n[d] = 0;
         return 1'b0;
      end
      if (!(v && rdy)) return 1'b0;
      if (bad) begin
         err_exp[d] = 1'b1;
         return 1'b1;
      end
      s = c + 1;
      if (st_n[d] > 0 && st_start[d][st_n[d]-1] + hold[d] + gap[d] > s)
         s = st_start[d][st_n[d]-1] + hold[d] + gap[d];
      if (st_n[d] < MAXS) begin
         st_start[d][st_n[d]] = s;
         st_code[d][st_n[d]]  = int'(a);
         st_n[d]++;
      end
      return 1'b1;
   endfunction

   function automatic logic [2:0] enc(logic [7:0] y);
      return {y[4] | y[5] | y[6] | y[7], y[2] | y[3] | y[6] | y[7], y[1] | y[3] | y[5] | y[7]};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("y_a", 32'(y_a), 32'(m_y(0, cyc)));
      chk("done_a", 32'(done_a), 32'(m_done(0, cyc)));
      chk("busy_a", 32'(busy_a), 32'(m_busy(0, cyc)));
      chk("ready_a", 32'(rdy_a), 32'(m_ready(0, cyc)));
      chk("y_b", 32'(y_b), 32'(m_y(1, cyc)));
      chk("done_b", 32'(done_b), 32'(m_done(1, cyc)));
      chk("busy_b", 32'(busy_b), 32'(m_busy(1, cyc)));
      chk("ready_b", 32'(rdy_b), 32'(m_ready(1, cyc)));
`ifdef DEC_PARITY_EN
      chk("err_a", 32'(err_a), 32'(err_exp[0]));
      chk("err_b", 32'(err_b), 32'(err_exp[1]));
`endif
   endtask

   task automatic tick();
      logic ra, rb, bad_a, bad_b;
      ra = m_ready(0, cyc);
      rb = m_ready(1, cyc);
      bad_a = 1'b0;
      bad_b = 1'b0;
`ifdef DEC_PARITY_EN
      bad_a = ^{a_a, p_a};
      bad_b = ^{a_b, p_b};
`endif
      @(posedge clk);
      acc_a = m_edge(0, cyc, v_a, a_a, bad_a, ra);
      acc_b = m_edge(1, cyc, v_b, a_b, bad_b, rb);
      cyc++;
      @(negedge clk);
      check_all();
      if (rec_on && rec_q.size() < 15) rec_q.push_back(y_a);
      if (done_b === 1'b1) done_b_cnt++;
   endtask

   initial begin
      int t0, acc_cyc, c_before;
      hold[0] = H_A; gap[0] = G_A; hold[1] = H_B; gap[1] = G_B;
      st_n[0] = 0; st_n[1] = 0; err_exp[0] = 1'b0; err_exp[1] = 1'b0;
      cyc = 0; checks = 0; errors = 0; done_b_cnt = 0; rec_on = 1'b0;
      rst = 1'b1; v_a = 1'b0; v_b = 1'b0; a_a = 3'd0; a_b = 3'd0;
`ifdef DEC_PARITY_EN
      p_a = 1'b0; p_b = 1'b0;
`endif
      @(negedge clk);

      // Reset for two cycles, then idle.
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Single codes 0..7, each strobe re-encoded back to its code.
      for (int n = 0; n < 8; n++) begin
         v_a = 1'b1; a_a = 3'(n);
`ifdef DEC_PARITY_EN
         p_a = ^a_a;
`endif
         tick();
         v_a = 1'b0;
         for (int k = 0; k < H_A; k++) begin
            chk("enc_code", 32'(enc(y_a)), 32'(n));
            tick();
         end
         tick();
      end

      // Queueing: 3, then 6 in the 2nd drive cycle, then 1 held until taken.
      t0 = cyc; rec_q.delete(); rec_on = 1'b1;
      v_a = 1'b1; a_a = 3'd3;
`ifdef DEC_PARITY_EN
      p_a = ^a_a;
`endif
      tick();
      v_a = 1'b0;
      tick();
      v_a = 1'b1; a_a = 3'd6;
`ifdef DEC_PARITY_EN
      p_a = ^a_a;
`endif
      tick();
      chk("q_acc6", 32'(acc_a), 32'd1);
      a_a = 3'd1;
`ifdef DEC_PARITY_EN
      p_a = ^a_a;
`endif
      acc_cyc = -1;
      for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
         c_before = cyc;
         tick();
         if (acc_a) acc_cyc = c_before;
      end
      v_a = 1'b0;
      chk("q_acc1_cycle", 32'(acc_cyc), 32'(t0 + 6));
      repeat (10) tick();
      rec_on = 1'b0;
      chk("q_len", 32'(rec_q.size()), 32'd15);
      for (int i = 0; i < 15 && i < rec_q.size(); i++) chk("q_seq", 32'(rec_q[i]), 32'(q_exp[i]));

      // Reset in the 3rd drive cycle of code 4 with code 2 pending.
      v_a = 1'b1; a_a = 3'd4;
`ifdef DEC_PARITY_EN
      p_a = ^a_a;
`endif
      tick();
      a_a = 3'd2;
`ifdef DEC_PARITY_EN
      p_a = ^a_a;
`endif
      tick();
      chk("r_acc2", 32'(acc_a), 32'd1);
      v_a = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("r_y", 32'(y_a), 32'd0);
      chk("r_busy", 32'(busy_a), 32'd0);
      chk("r_done", 32'(done_a), 32'd0);
      rst = 1'b0;
      repeat (10) tick();

      // HOLD=1, GAP=0 back-to-back codes 5,2,7.
      done_b_cnt = 0;
      v_b = 1'b1; a_b = 3'd5;
`ifdef DEC_PARITY_EN
      p_b = ^a_b;
`endif
      tick();
      chk("b2b_y5", 32'(y_b), 32'h20);
      a_b = 3'd2;
`ifdef DEC_PARITY_EN
      p_b = ^a_b;
`endif
      tick();
      chk("b2b_y2", 32'(y_b), 32'h04);
      a_b = 3'd7;
`ifdef DEC_PARITY_EN
      p_b = ^a_b;
`endif
      tick();
      chk("b2b_y7", 32'(y_b), 32'h80);
      v_b = 1'b0;
      repeat (4) tick();
      chk("b2b_done_cnt", 32'(done_b_cnt), 32'd3);

      // Random traffic on both instances with occasional resets.
      for (int k = 0; k < 400; k++) begin
         if (!v_a || acc_a) begin
            v_a = ($urandom_range(0, 2) != 0);
            a_a = 3'($urandom_range(0, 7));
`ifdef DEC_PARITY_EN
            p_a = (^a_a) ^ ($urandom_range(0, 7) == 0);
`endif
         end
         if (!v_b || acc_b) begin
            v_b = ($urandom_range(0, 2) != 0);
            a_b = 3'($urandom_range(0, 7));
`ifdef DEC_PARITY_EN
            p_b = (^a_b) ^ ($urandom_range(0, 7) == 0);
`endif
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
